// File: rtl/pipe_pkg.sv
// Shared types and defaults for the two-entry valid/ready skid stage.
// State encoding doubles as the occupancy count driven on the count port.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   localparam int DEFAULT_WIDTH = 64;

endpackage

// File: rtl/skid_ctrl.sv
// Occupancy FSM for the skid stage: registers the handshake outputs and
// decodes the per-cycle load enables for the main/skid data registers.
//
//  state | meaning
//  EMPTY | nothing held, out_valid=0, in_ready=1
//  ONE   | main holds the only entry
//  TWO   | main holds oldest, skid holds newest, in_ready=0
module skid_ctrl
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       in_valid,
   input  logic       out_ready,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] count,
   output logic       load_main,
   output logic       load_skid,
   output logic       sel_skid
);

   skid_state_t state;
   skid_state_t state_nxt;
   logic        accept;
   logic        pop;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      load_main = 1'b0;
      load_skid = 1'b0;
      sel_skid  = 1'b0;
      unique case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (accept && !pop) begin
               state_nxt = TWO;
               load_skid = 1'b1;
            end else if (accept && pop) begin
               load_main = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            sel_skid = 1'b1;
            if (pop) begin
               state_nxt = ONE;
               load_main = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush and reset discard any same-cycle handshake entirely.
      if (reset || flush) begin
         state_nxt = EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
      end
   end

   // Outputs are registered alongside state so in_ready has no path from out_ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         count     <= 2'd0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt != TWO);
         out_valid <= (state_nxt != EMPTY);
         count     <= state_nxt;
      end
   end

   a_no_accept_when_full : assert property (@(posedge clk) disable iff (reset)
      !(state == TWO && accept));
   a_count_legal : assert property (@(posedge clk) disable iff (reset)
      count != 2'd3);

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready pipeline stage with flush: control FSM plus the main
// (output) and skid enable registers, with main fed from in_data or skid.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   logic             load_main;
   logic             load_skid;
   logic             sel_skid;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] main_d;

   skid_ctrl u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .count     (count),
      .load_main (load_main),
      .load_skid (load_skid),
      .sel_skid  (sel_skid)
   );

   assign main_d = sel_skid ? skid_q : in_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main) main_q <= main_d;
         if (load_skid) skid_q <= in_data;
      end
   end

   assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: reset, streaming, backpressure,
// full-state handshake, flush and mid-operation reset.
module tb_pipe_skid_stage;

   localparam int WIDTH = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       count;

   int vectors = 0;
   int miscompares = 0;

   pipe_skid_stage #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [1:0] c, input logic [63:0] d);
      chk({tag, " count"}, 64'(count), 64'(c));
      chk({tag, " out_valid"}, 64'(out_valid), 64'(c != 2'd0));
      chk({tag, " in_ready"}, 64'(in_ready), 64'(c != 2'd2));
      if (c != 2'd0) chk({tag, " out_data"}, out_data, d);
   endtask

   task automatic push(input logic [63:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      // 1. reset with an offered beat that must be discarded
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b0;
      step();
      step();
      reset = 1'b0; in_valid = 1'b0;
      chk("rst count", 64'(count), 64'd0);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out_data", out_data, 64'd0);
      chk("rst in_ready", 64'(in_ready), 64'd1);

      // 2. streaming at full rate
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = 64'(i);
         step();
         chk_state($sformatf("stream%0d", i), 2'd1, 64'(i));
      end
      in_valid = 1'b0;
      step();
      chk_state("stream drain", 2'd0, 64'd0);

      // 3. backpressure absorbs one extra beat
      out_ready = 1'b0;
      push(64'hA);
      chk_state("bp first", 2'd1, 64'hA);
      push(64'hB);
      chk_state("bp full", 2'd2, 64'hA);
      out_ready = 1'b1;
      step();
      chk_state("bp pop A", 2'd1, 64'hB);
      step();
      chk_state("bp pop B", 2'd0, 64'd0);

      // 4. offer while full: C must wait, order A,B,C kept
      out_ready = 1'b0;
      push(64'hA);
      push(64'hB);
      step();
      chk_state("full hold", 2'd2, 64'hA);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 64'hC;
      step();
      chk_state("full offer", 2'd1, 64'hB);
      step();
      chk_state("C after B", 2'd1, 64'hC);
      in_valid = 1'b0;
      step();
      chk_state("C drained", 2'd0, 64'd0);

      // 5. flush from TWO with simultaneous handshakes
      out_ready = 1'b0;
      push(64'hA);
      push(64'hB);
      chk_state("pre flush", 2'd2, 64'hA);
      flush = 1'b1; in_valid = 1'b1; in_data = 64'hD; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk_state("flush", 2'd0, 64'd0);
      step();
      chk_state("post flush", 2'd0, 64'd0);
      // flush from ONE with an accept: F must never surface
      out_ready = 1'b0;
      push(64'hE);
      flush = 1'b1; in_valid = 1'b1; in_data = 64'hF;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk_state("flush one", 2'd0, 64'd0);
      out_ready = 1'b1;
      push(64'h7);
      chk_state("after flush push", 2'd1, 64'h7);
      step();
      chk_state("after flush drain", 2'd0, 64'd0);

      // 6. reset wins over flush mid-operation
      out_ready = 1'b0;
      push(64'hA);
      push(64'hB);
      chk_state("pre reset", 2'd2, 64'hA);
      reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 64'h9;
      step();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      chk_state("midreset", 2'd0, 64'd0);
      chk("midreset out_data", out_data, 64'd0);
      push(64'h5);
      chk_state("push 5", 2'd1, 64'h5);
      out_ready = 1'b1;
      step();
      chk_state("5 alone", 2'd0, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
